// File: rtl/record_serializer.sv
// record_serializer: pops ring-buffer records and streams them to uart_tx as binary or ASCII hex
module record_serializer #(
    parameter int          DW        = 48,
    parameter bit          SYNC_EN   = 1'b1,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [7:0]  OVF_BYTE  = 8'h5A
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read_empty,
    output logic          read_clock_enable,
    input  logic [DW-1:0] read_data,
    input  logic          overflow,
    input  logic          hex_mode,
    input  logic          uart_ready,
    output logic          uart_clock_enable,
    output logic [7:0]    uart_data,
    output logic          busy
);
    if (DW % 8 != 0 || DW < 8) begin : g_bad_dw
        $error("record_serializer: DW must be a multiple of 8 and at least 8");
    end

    localparam int NB = DW / 8;
    localparam int NH = DW / 4;
    localparam int IW = $clog2(DW / 4 + 4);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] EMIT  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    logic [2:0]    state;
    logic [DW-1:0] sr;
    logic          hex_r;
    logic          ovf_r;
    logic          ovf_pending;
    logic [IW-1:0] idx;

    logic [DW-1:0] c_sr;
    logic          c_hex;
    logic          c_ovf;
    logic [IW-1:0] c_idx;
    logic [IW-1:0] pre_n;
    logic          c_in_pre;
    logic          c_is_data;
    logic          c_last;
    logic [7:0]    c_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    // Byte selection for the current position; in LATCH the record is taken straight from the inputs
    // so the first byte can be registered on the same edge that captures the record.
    always_comb begin
        c_sr      = (state == LATCH) ? read_data : sr;
        c_hex     = (state == LATCH) ? hex_mode : hex_r;
        c_ovf     = (state == LATCH) ? ovf_pending : ovf_r;
        c_idx     = (state == LATCH) ? '0 : idx;
        pre_n     = {{(IW-1){1'b0}}, c_ovf | (!c_hex & SYNC_EN)};
        c_in_pre  = c_idx < pre_n;
        c_is_data = !c_in_pre && (c_idx < pre_n + (c_hex ? IW'(NH) : IW'(NB)));
        c_last    = c_idx == pre_n + (c_hex ? IW'(NH + 1) : IW'(NB - 1));
        c_byte    = c_in_pre  ? (c_hex ? 8'h21 : (c_ovf ? OVF_BYTE : SYNC_BYTE)) :
                    c_is_data ? (c_hex ? hex_char(c_sr[DW-1 -: 4]) : c_sr[DW-1 -: 8]) :
                    (c_idx == pre_n + IW'(NH)) ? 8'h0D : 8'h0A;
    end

    // Sequencer; the strobe is registered from uart_ready sampled on the edge entering the strobe cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            sr                <= '0;
            hex_r             <= 1'b0;
            ovf_r             <= 1'b0;
            ovf_pending       <= 1'b0;
            idx               <= '0;
            read_clock_enable <= 1'b0;
            uart_clock_enable <= 1'b0;
            uart_data         <= 8'h00;
            busy              <= 1'b0;
        end else begin
            ovf_pending <= overflow | (ovf_pending & (state != LATCH));
            case (state)
                IDLE: begin
                    if (!read_empty) begin
                        state             <= POP;
                        read_clock_enable <= 1'b1;
                        busy              <= 1'b1;
                    end
                end
                POP: begin
                    state             <= LATCH;
                    read_clock_enable <= 1'b0;
                end
                LATCH: begin
                    sr                <= read_data;
                    hex_r             <= hex_mode;
                    ovf_r             <= ovf_pending;
                    idx               <= '0;
                    state             <= EMIT;
                    uart_clock_enable <= uart_ready;
                    uart_data         <= c_byte;
                end
                EMIT: begin
                    if (uart_clock_enable) begin
                        uart_clock_enable <= 1'b0;
                        idx               <= idx + 1'b1;
                        if (c_is_data) sr <= hex_r ? {sr[DW-5:0], 4'h0} : {sr[DW-9:0], 8'h00};
                        state             <= c_last ? IDLE : HOLD;
                        busy              <= !c_last;
                    end else begin
                        uart_clock_enable <= uart_ready;
                    end
                end
                HOLD: begin
                    state             <= EMIT;
                    uart_clock_enable <= uart_ready;
                    uart_data         <= c_byte;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_record_serializer.sv
// tb_record_serializer: directed and randomized checks of record_serializer against a byte-stream model
module tb_record_serializer;
    localparam int DW = 48;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          read_empty = 1'b1;
    logic          read_clock_enable;
    logic [DW-1:0] read_data = '0;
    logic          overflow = 1'b0;
    logic          hex_mode = 1'b0;
    logic          uart_ready = 1'b1;
    logic          uart_clock_enable;
    logic [7:0]    uart_data;
    logic          busy;

    int total = 0, bad = 0, cyc = 0, pops = 0, viol = 0, underflow = 0;
    bit last_rdy = 1'b0, rand_rdy = 1'b0;
    logic [DW-1:0] rb[$];
    logic [7:0] got[$], exp_q[$];
    int scyc[$], pcyc[$];

    always #5 clock = ~clock;

    record_serializer #(.DW(DW)) dut (
        .clock(clock), .reset(reset), .read_empty(read_empty), .read_clock_enable(read_clock_enable),
        .read_data(read_data), .overflow(overflow), .hex_mode(hex_mode), .uart_ready(uart_ready),
        .uart_clock_enable(uart_clock_enable), .uart_data(uart_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic popped;
        @(negedge clock);
        popped = read_clock_enable;
        if (uart_clock_enable === 1'b1) begin
            got.push_back(uart_data);
            scyc.push_back(cyc);
            if (!last_rdy) viol++;
        end
        if (popped === 1'b1) begin
            pops++;
            pcyc.push_back(cyc);
        end
        last_rdy = uart_ready;
        @(posedge clock);
        #1;
        cyc++;
        if (popped === 1'b1) begin
            if (rb.size() == 0) underflow++;
            else read_data = rb.pop_front();
            read_empty = (rb.size() == 0);
        end
        if (rand_rdy) uart_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [DW-1:0] rec);
        rb.push_back(rec);
        read_empty = 1'b0;
    endtask

    task automatic model(input logic [DW-1:0] rec, input bit hx, input bit ov);
        logic [3:0] n;
        if (hx) begin
            if (ov) exp_q.push_back(8'h21);
            for (int i = DW / 4 - 1; i >= 0; i--) begin
                n = rec[4*i +: 4];
                exp_q.push_back(n < 4'd10 ? 8'd48 + 8'(n) : 8'd87 + 8'(n));
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            exp_q.push_back(ov ? 8'h5A : 8'hA5);
            for (int i = DW / 8 - 1; i >= 0; i--) exp_q.push_back(rec[8*i +: 8]);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((rb.size() != 0 || busy) && n < 2000) begin
            tick();
            n++;
        end
        tick();
        tick();
        check({tag, " idle"}, busy, 0);
    endtask

    task automatic compare(input string tag);
        check({tag, " count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s byte%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
        scyc.delete();
        pcyc.delete();
        pops = 0;
    endtask

    initial begin
        logic [DW-1:0] rec, rec2;
        bit ov;
        int n;
        tick();
        tick();
        check("reset rce", read_clock_enable, 0);
        check("reset uce", uart_clock_enable, 0);
        check("reset data", uart_data, 0);
        check("reset busy", busy, 0);
        reset = 1'b0;
        got.delete(); scyc.delete(); pcyc.delete(); pops = 0;
        for (int i = 0; i < 4; i++) tick();
        check("empty no pop", pops, 0);
        check("empty idle", busy, 0);

        rec = 48'h123456789ABC;
        model(rec, 0, 0);
        push(rec);
        drain("bin");
        check("bin pops", pops, 1);
        if (scyc.size() > 0 && pcyc.size() > 0) check("bin latency", scyc[0] - pcyc[0], 2);
        for (int i = 1; i < scyc.size(); i++) check($sformatf("bin gap%0d", i), scyc[i] - scyc[i-1], 2);
        compare("bin");

        hex_mode = 1'b1;
        model(rec, 1, 0);
        push(rec);
        drain("hex");
        compare("hex");

        hex_mode = 1'b0;
        overflow = 1'b1;
        tick();
        overflow = 1'b0;
        tick();
        rec = 48'h000000000001;
        model(rec, 0, 1);
        push(rec);
        drain("ovf");
        compare("ovf");
        rec = 48'hCAFEF00D0042;
        model(rec, 0, 0);
        push(rec);
        drain("after ovf");
        compare("after ovf");

        rec = 48'hDEADBEEF5511;
        model(rec, 0, 0);
        push(rec);
        n = 0;
        while (got.size() < 3 && n < 200) begin tick(); n++; end
        uart_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("stall strobes", got.size(), 3);
        uart_ready = 1'b1;
        drain("stall");
        check("stall pops", pops, 1);
        compare("stall");

        rec = 48'h0102030405A6;
        rec2 = 48'hF0E0D0C0B0A0;
        model(rec, 0, 0);
        model(rec2, 0, 0);
        push(rec);
        push(rec2);
        drain("b2b");
        check("b2b pops", pops, 2);
        if (pcyc.size() == 2 && scyc.size() >= 7) check("b2b pop after last", pcyc[1] > scyc[6], 1);
        compare("b2b");

        rec = 48'h111111111111;
        rec2 = 48'h9876543210FE;
        push(rec);
        push(rec2);
        n = 0;
        while (got.size() < 3 && n < 200) begin tick(); n++; end
        reset = 1'b1;
        tick();
        check("midrst rce", read_clock_enable, 0);
        check("midrst uce", uart_clock_enable, 0);
        check("midrst data", uart_data, 0);
        check("midrst busy", busy, 0);
        reset = 1'b0;
        got.delete(); scyc.delete(); pcyc.delete(); pops = 0;
        model(rec2, 0, 0);
        drain("midrst");
        compare("midrst");

        rand_rdy = 1'b1;
        for (int r = 0; r < 24; r++) begin
            rec = DW'({$urandom, $urandom});
            hex_mode = 1'($urandom_range(0, 1));
            ov = ($urandom_range(0, 3) == 0);
            if (ov) begin
                overflow = 1'b1;
                tick();
                overflow = 1'b0;
            end
            model(rec, hex_mode, ov);
            push(rec);
            drain($sformatf("rand%0d", r));
            compare($sformatf("rand%0d", r));
        end

        check("strobe without ready", viol, 0);
        check("pop from empty", underflow, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
